// File: rtl/byte_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// byte_serial_adder_ctrl
//   Wide (8*WORDS-bit) add/subtract performed one byte per clock through a
//   single shared 8-bit ripple-carry adder (RCA8). Operands are latched on an
//   accepted start, lanes are processed LSB-first with the carry registered
//   between lanes, and completion is flagged by a one-cycle done pulse.
//
//   Ports
//     clk_i          rising-edge clock
//     rst_i          synchronous reset, active high
//     start_i        request pulse, accepted only when idle
//     sub_i          0 = a + b + carryInput, 1 = a - b
//     a_i, b_i       operands (N = 8*WORDS bits)
//     carryInput_i   carry-in for add; ignored for subtract
//     busy_o         operation in flight (includes the done cycle)
//     done_o         one-cycle completion pulse
//     sum_o          result register
//     carryOutput_o  final carry (subtract: 1 = no borrow)
//     overflow_o     two's-complement signed overflow
// ---------------------------------------------------------------------------

// 8-bit ripple-carry adder: the only arithmetic element in this block.
module RCA8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] s_o,
    output logic       c_o
);
    logic [8:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int k = 0; k < 8; k++) begin
            s_o[k]   = a_i[k] ^ b_i[k] ^ c[k];
            c[k + 1] = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
        end
        c_o = c[8];
    end
endmodule

module byte_serial_adder_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 sub_i,
    input  logic [8*WORDS-1:0]   a_i,
    input  logic [8*WORDS-1:0]   b_i,
    input  logic                 carryInput_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [8*WORDS-1:0]   sum_o,
    output logic                 carryOutput_o,
    output logic                 overflow_o
);
    localparam int N  = 8 * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;     // already inverted for subtract
    logic            c_q, c_d;     // inter-lane carry
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            co_q, co_d;
    logic            ov_q, ov_d;

    logic [7:0]      lane_a, lane_b, rca_s;
    logic            rca_c;

    assign lane_a = a_q[{idx_q, 3'b000} +: 8];
    assign lane_b = b_q[{idx_q, 3'b000} +: 8];

    RCA8 u_rca (
        .a_i (lane_a),
        .b_i (lane_b),
        .c_i (c_q),
        .s_o (rca_s),
        .c_o (rca_c)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_RUN;
            S_RUN:  if (idx_q == LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
    end

    // Datapath next-state
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        idx_d = idx_q;
        sum_d = sum_q;
        co_d  = co_q;
        ov_d  = ov_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d   = a_i;
                    // Subtract as a + ~b + 1
                    b_d   = sub_i ? ~b_i : b_i;
                    c_d   = sub_i ? 1'b1 : carryInput_i;
                    idx_d = '0;
                    sum_d = '0;
                    co_d  = 1'b0;
                    ov_d  = 1'b0;
                end
            end
            S_RUN: begin
                sum_d[{idx_q, 3'b000} +: 8] = rca_s;
                c_d = rca_c;
                if (idx_q == LAST) begin
                    co_d = rca_c;
                    // rca_s[7] is the result's sign bit on the last lane
                    ov_d = (a_q[N-1] == b_q[N-1]) && (rca_s[7] != a_q[N-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            idx_q <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            idx_q <= idx_d;
            sum_q <= sum_d;
            co_q  <= co_d;
            ov_q  <= ov_d;
        end
    end

    assign sum_o         = sum_q;
    assign carryOutput_o = co_q;
    assign overflow_o    = ov_q;
endmodule
